pcie_ep_train_resp: RTL

PCIE_EP_TRAIN_RESP -- requirements
Module: pcie_ep_train_resp

---
 rtl/pcie_ep_pkg.sv | 35 +++
 rtl/pcie_ep_os_detect.sv | 76 +++++++
 rtl/pcie_ep_train_resp.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pcie_ep_pkg.sv
// Shared LTSSM state encoding, 10-bit symbol constants and the TS ordered-set symbol table.
package pcie_ep_pkg;

  typedef enum logic [1:0] {
    ST_DETECT      = 2'd0,
    ST_POLL_ACTIVE = 2'd1,
    ST_POLL_CONFIG = 2'd2,
    ST_L0          = 2'd3
  } ltssm_e;

  // bit9 = 0, bit8 = K flag, [7:0] = byte
  typedef logic [9:0] sym_t;

  localparam sym_t       COM    = 10'h1BC;
  localparam sym_t       PAD    = 10'h1F7;
  localparam sym_t       IDLE   = 10'h000;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  localparam logic [7:0] N_FTS  = 8'h80;
  localparam logic [7:0] RATE   = 8'h02;

  function automatic sym_t ts_symbol(input logic [3:0] pos, input logic [7:0] id);
    sym_t s;
    case (pos)
      4'd0:       s = COM;
      4'd1, 4'd2: s = PAD;
      4'd3:       s = {2'b00, N_FTS};
      4'd4:       s = {2'b00, RATE};
      4'd5:       s = IDLE;
      default:    s = {2'b00, id};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pcie_ep_os_detect.sv
// Lane-0 TS1/TS2 ordered-set parser; ok pulses one cycle after symbol 15, error pulse one
// cycle after the first bad ID symbol. No backpressure: one symbol consumed every cycle.
module pcie_ep_os_detect
  import pcie_ep_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] sym_i,
  output logic       ts1_ok_o,
  output logic       ts2_ok_o,
  output logic       os_err_o
);

  logic [3:0] pos_q, pos_d;
  logic [7:0] id_q, id_d;
  logic       ts1_q, ts1_d, ts2_q, ts2_d, err_q, err_d;
  logic       is_com, id_valid;

  always_comb begin
    is_com = (sym_i == COM);
    // pos6 chooses the set type; the remaining nine IDs must repeat it exactly
    if (pos_q == 4'd6) begin
      id_valid = (sym_i == {2'b00, TS1_ID}) || (sym_i == {2'b00, TS2_ID});
    end else begin
      id_valid = (sym_i == {2'b00, id_q});
    end
  end

  always_comb begin
    pos_d = pos_q;
    id_d  = id_q;
    ts1_d = 1'b0;
    ts2_d = 1'b0;
    err_d = 1'b0;
    if (is_com) begin
      pos_d = 4'd1;
    end else if (pos_q != 4'd0) begin
      if (pos_q < 4'd6) begin
        pos_d = pos_q + 4'd1;
      end else if (!id_valid) begin
        pos_d = 4'd0;
        err_d = 1'b1;
      end else begin
        if (pos_q == 4'd6) id_d = sym_i[7:0];
        if (pos_q == 4'd15) begin
          pos_d = 4'd0;
          ts1_d = (id_q == TS1_ID);
          ts2_d = (id_q == TS2_ID);
        end else begin
          pos_d = pos_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_q <= 4'd0;
      id_q  <= 8'd0;
      ts1_q <= 1'b0;
      ts2_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      id_q  <= id_d;
      ts1_q <= ts1_d;
      ts2_q <= ts2_d;
      err_q <= err_d;
    end
  end

  assign ts1_ok_o = ts1_q;
  assign ts2_ok_o = ts2_q;
  assign os_err_o = err_q;

endmodule

// File: rtl/pcie_ep_train_resp.sv
// Endpoint link-training responder: DETECT -> POLL_ACTIVE -> POLL_CONFIG -> L0 with TS generator.
// Outputs are registered from the next-state decode, so they line up with LtssmState.
module pcie_ep_train_resp
  import pcie_ep_pkg::*;
#(
  parameter int NUMLANES       = 4,
  parameter int DETECT_CYCLES  = 16,
  parameter int TS_RX_REQ      = 8,
  parameter int TS_TX_MIN      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUMLANES*10-1:0]   LinkIn,
  output logic [NUMLANES*10-1:0]   LinkOut,
  output logic [NUMLANES-1:0]      ElecIdleOut,
  output logic                     LinkUp,
  output logic [1:0]               LtssmState
);

  localparam int MAXC  = (TIMEOUT_CYCLES > DETECT_CYCLES) ? TIMEOUT_CYCLES : DETECT_CYCLES;
  localparam int TMO_W = $clog2(MAXC + 1);
  localparam int SET_W = 8;
  localparam logic [SET_W:0] TX_MIN_V = (SET_W + 1)'(TS_TX_MIN);
  localparam logic [4:0]     RX_REQ_V = 5'(TS_RX_REQ);

  ltssm_e                 state_q, state_d;
  logic [3:0]             txpos_q, txpos_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [3:0]             rx_q, rx_d;
  logic                   seen_q, seen_d;
  logic [SET_W-1:0]       sets_q, sets_d, after_q, after_d;
  logic [NUMLANES*10-1:0] link_out_q, link_out_d;
  logic [NUMLANES-1:0]    eidle_q, eidle_d;
  logic                   link_up_q, link_up_d;
  logic                   ts1_ok, ts2_ok, os_err;
  logic                   at_bnd, tmo_hit, det_done, rx_ok, sent_ok, after_ok, entry;
  logic [SET_W:0]         sent_now, after_now;
  sym_t                   sym_d;

  pcie_ep_os_detect u_os_detect (
    .Clk      (Clk),
    .Reset    (Reset),
    .sym_i    (LinkIn[9:0]),
    .ts1_ok_o (ts1_ok),
    .ts2_ok_o (ts2_ok),
    .os_err_o (os_err)
  );

  if (NUMLANES > 1) begin : g_unused
    logic unused_lanes;
    assign unused_lanes = ^LinkIn[NUMLANES*10-1:10];
  end

  assign at_bnd    = (txpos_q == 4'd15);
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign det_done  = (tmo_q == TMO_W'(DETECT_CYCLES - 1));
  // set counts include the set finishing in this boundary cycle
  assign sent_now  = {1'b0, sets_q} + {{SET_W{1'b0}}, 1'b1};
  assign after_now = {1'b0, after_q} + {{SET_W{1'b0}}, seen_q};
  assign rx_ok     = ({1'b0, rx_q} >= RX_REQ_V);
  assign sent_ok   = (sent_now >= TX_MIN_V);
  assign after_ok  = (after_now >= TX_MIN_V);
  assign entry     = (state_d != state_q);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_DETECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DETECT:      if (det_done) state_d = ST_POLL_ACTIVE;
      ST_POLL_ACTIVE: begin
        if (tmo_hit)                          state_d = ST_DETECT;
        else if (at_bnd && rx_ok && sent_ok)  state_d = ST_POLL_CONFIG;
      end
      ST_POLL_CONFIG: begin
        if (tmo_hit)                          state_d = ST_DETECT;
        else if (at_bnd && rx_ok && after_ok) state_d = ST_L0;
      end
      ST_L0:          if (ts1_ok) state_d = ST_POLL_ACTIVE;
      default:        state_d = ST_DETECT;
    endcase
  end

  always_comb begin
    txpos_d = txpos_q + 4'd1;
    tmo_d   = (tmo_q != '1) ? tmo_q + TMO_W'(1) : tmo_q;
    rx_d    = rx_q;
    seen_d  = seen_q;
    sets_d  = sets_q;
    after_d = after_q;
    if (entry) begin
      txpos_d = 4'd0;
      tmo_d   = '0;
      rx_d    = 4'd0;
      seen_d  = 1'b0;
      sets_d  = '0;
      after_d = '0;
    end else if (state_q == ST_POLL_ACTIVE) begin
      if (os_err)                                  rx_d = 4'd0;
      else if ((ts1_ok || ts2_ok) && rx_q != 4'hF) rx_d = rx_q + 4'd1;
      if (at_bnd && sets_q != '1)                  sets_d = sets_q + SET_W'(1);
    end else if (state_q == ST_POLL_CONFIG) begin
      if (os_err || ts1_ok)                        rx_d = 4'd0;
      else if (ts2_ok && rx_q != 4'hF)             rx_d = rx_q + 4'd1;
      if (ts2_ok)                                  seen_d = 1'b1;
      if (at_bnd && seen_q && after_q != '1)       after_d = after_q + SET_W'(1);
    end
  end

  always_comb begin
    sym_d     = IDLE;
    eidle_d   = '0;
    link_up_d = 1'b0;
    case (state_d)
      ST_DETECT:      eidle_d = '1;
      ST_POLL_ACTIVE: sym_d = ts_symbol(txpos_d, TS1_ID);
      ST_POLL_CONFIG: sym_d = ts_symbol(txpos_d, TS2_ID);
      ST_L0:          link_up_d = 1'b1;
      default:        eidle_d = '1;
    endcase
    link_out_d = {NUMLANES{sym_d}};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      txpos_q    <= 4'd0;
      tmo_q      <= '0;
      rx_q       <= 4'd0;
      seen_q     <= 1'b0;
      sets_q     <= '0;
      after_q    <= '0;
      link_out_q <= '0;
      eidle_q    <= '1;
      link_up_q  <= 1'b0;
    end else begin
      txpos_q    <= txpos_d;
      tmo_q      <= tmo_d;
      rx_q       <= rx_d;
      seen_q     <= seen_d;
      sets_q     <= sets_d;
      after_q    <= after_d;
      link_out_q <= link_out_d;
      eidle_q    <= eidle_d;
      link_up_q  <= link_up_d;
    end
  end

  assign LinkOut     = link_out_q;
  assign ElecIdleOut = eidle_q;
  assign LinkUp      = link_up_q;
  assign LtssmState  = state_q;

endmodule
